// File: rtl/tick_gen_pkg.sv
// Shared types and source-select codes for the tick_gen strobe generator.
package tick_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARM,
        ST_RUN,
        ST_SWITCH
    } tick_state_t;

    localparam logic [1:0] SEL_DIV2 = 2'd0;
    localparam logic [1:0] SEL_DIV4 = 2'd1;
    localparam logic [1:0] SEL_DIV8 = 2'd2;
    localparam logic [1:0] SEL_RAW  = 2'd3;

endpackage

// File: rtl/edge_rise.sv
// Rising-edge detector on a synchronous level; load reports no edge for the
// current cycle while the history still takes the current level.
module edge_rise (
    input  logic clk,
    input  logic reset,
    input  logic level,
    input  logic load,
    output logic rise
);

    logic hist;

    // NOTE: state registers use non-blocking assignment so every flop samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hist <= 1'b0;
        end else begin
            hist <= level;
        end
    end

    // A level that is already high when loaded must not count as an edge.
    assign rise = level & ~hist & ~load;

endmodule

// File: rtl/tick_gen.sv
// Clock-enable strobe generator: one stb per rising edge of the selected
// divided level, one tick every max(period,1) strobes, glitch-free switching.
module tick_gen
    import tick_gen_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       div_in,
    input  logic             enable,
    input  logic [1:0]       sel,
    input  logic             sel_load,
    input  logic [CNT_W-1:0] period,
    output logic             stb,
    output logic             tick,
    output logic [1:0]       sel_cur,
    output logic             busy
);

    tick_state_t      state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] period_q;
    logic [CNT_W-1:0] cnt_last;
    logic [1:0]       pending;
    logic [1:0]       pend_nxt;
    logic             settle;
    logic             level;
    logic             rise;
    logic             hist_load;
    logic             counting;
    logic             fire;
    logic             at_last;

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        level = 1'b0;
        case (sel_cur)
            SEL_DIV2: level = div_in[0];
            SEL_DIV4: level = div_in[1];
            SEL_DIV8: level = div_in[2];
            SEL_RAW:  level = 1'b1;
            default:  level = 1'b0;
        endcase
    end

    // The first cycle of ARM and of a new source only primes the history.
    assign hist_load = (state == ST_ARM) || settle;

    edge_rise u_edge_rise (
        .clk   (clk),
        .reset (reset),
        .level (level),
        .load  (hist_load),
        .rise  (rise)
    );

    assign counting = (state == ST_RUN) || (state == ST_SWITCH);
    assign fire     = counting && !settle && ((sel_cur == SEL_RAW) || rise);
    assign cnt_last = (period_q == '0) ? '0 : period_q - CNT_W'(1);
    assign at_last  = (cnt == cnt_last);
    assign pend_nxt = sel_load ? sel : pending;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            period_q <= '0;
            pending  <= SEL_DIV2;
            settle   <= 1'b0;
            stb      <= 1'b0;
            tick     <= 1'b0;
            sel_cur  <= SEL_DIV2;
            busy     <= 1'b0;
        end else begin
            stb    <= 1'b0;
            tick   <= 1'b0;
            settle <= 1'b0;
            if (!enable) begin
                state <= ST_IDLE;
                busy  <= 1'b0;
                cnt   <= '0;
                if (sel_load) begin
                    sel_cur <= sel;
                end
            end else begin
                if (fire) begin
                    stb <= 1'b1;
                    if (at_last) begin
                        tick     <= 1'b1;
                        period_q <= period;
                    end
                    cnt <= (at_last || state == ST_SWITCH) ? '0 : cnt + CNT_W'(1);
                end
                case (state)
                    ST_IDLE: begin
                        cnt   <= '0;
                        state <= ST_ARM;
                        busy  <= 1'b1;
                        if (sel_load) begin
                            sel_cur <= sel;
                        end
                    end
                    ST_ARM: begin
                        period_q <= period;
                        state    <= ST_RUN;
                        busy     <= 1'b0;
                    end
                    ST_RUN: begin
                        if (sel_load && sel != sel_cur) begin
                            pending <= sel;
                            state   <= ST_SWITCH;
                            busy    <= 1'b1;
                        end
                    end
                    ST_SWITCH: begin
                        // The old source's strobe is the only safe hand-over point.
                        if (fire) begin
                            sel_cur <= pend_nxt;
                            state   <= ST_RUN;
                            busy    <= 1'b0;
                            settle  <= 1'b1;
                        end else if (sel_load) begin
                            pending <= sel;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
